// File: rtl/mesh_pkg.sv
// mesh_pkg: shared constants and types for the mesh network interface.
//   - PACKET_WIDTH default link/packet width
//   - packet field bit positions (vc, dest_x, dest_y)
//   - processor register addresses
//   - chan_state_t: state of a 1-entry channel buffer
package mesh_pkg;

    localparam int PACKET_WIDTH = 64;

    // Packet layout: [63] vc, [55:52] dest_x, [51:48] dest_y, [47:0] payload.
    localparam int VC_BIT     = 63;
    localparam int DEST_X_MSB = 55;
    localparam int DEST_X_LSB = 52;
    localparam int DEST_Y_MSB = 51;
    localparam int DEST_Y_LSB = 48;

    // Processor register map.
    localparam logic [1:0] ADDR_IBUF  = 2'd0;
    localparam logic [1:0] ADDR_ISTAT = 2'd1;
    localparam logic [1:0] ADDR_OBUF  = 2'd2;
    localparam logic [1:0] ADDR_OSTAT = 2'd3;

    typedef enum logic {
        CHAN_EMPTY = 1'b0,
        CHAN_FULL  = 1'b1
    } chan_state_t;

endpackage

// File: rtl/mesh_nic_if.sv
// mesh_nic_if: processor-side register bus of the NIC.
//   addr      register select (see mesh_pkg ADDR_*)
//   d_in      write data
//   d_out     registered read data (driven by the NIC)
//   nic_en    access enable
//   nic_wr_en 1 = write, 0 = read; qualified by nic_en
// Modports: master = processor, slave = NIC.
interface mesh_nic_if #(
    parameter int W = 64
) ();
    logic [1:0]   addr;
    logic [W-1:0] d_in;
    logic [W-1:0] d_out;
    logic         nic_en;
    logic         nic_wr_en;

    modport master (
        output addr, d_in, nic_en, nic_wr_en,
        input  d_out
    );

    modport slave (
        input  addr, d_in, nic_en, nic_wr_en,
        output d_out
    );
endinterface

// File: rtl/nic_chan_buf.sv
// nic_chan_buf: 1-entry channel buffer used once per NIC direction.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        capture load_data when empty (ignored while full)
//   load_data   data to capture
//   unload      release the entry when full (ignored while empty)
//   state       buffer state (CHAN_EMPTY / CHAN_FULL), registered
//   data        stored data; kept after unload so a late read sees it
module nic_chan_buf
    import mesh_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         unload,
    output chan_state_t  state,
    output logic [W-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CHAN_EMPTY;
            data  <= '0;
        end else begin
            case (state)
                CHAN_EMPTY: begin
                    if (load) begin
                        data  <= load_data;
                        state <= CHAN_FULL;
                    end
                end
                CHAN_FULL: begin
                    // A load on the same edge as an unload is dropped: the
                    // entry is still occupied when that edge is evaluated.
                    if (unload) begin
                        state <= CHAN_EMPTY;
                    end
                end
                default: state <= CHAN_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/mesh_nic.sv
// mesh_nic: network interface at a router's local port.
//   Injection: processor writes a packet to the output buffer; it is offered
//   to the router with net_so/net_do until net_ri accepts it.
//   Ejection: packets from the router (net_si/net_di) land in the input
//   buffer when net_ro is high; the processor reads them out.
// Ports:
//   clk     clock
//   reset   asynchronous active-low reset
//   bus     processor register bus (mesh_nic_if.slave)
//   net_so  / net_ri / net_do  link towards router local input
//   net_si  / net_ro / net_di  link from router local output
// Handshake: a link word moves on a rising edge where send and ready are
// both high; the sender holds data stable while send is high.
// Optional build macro MESH_NIC_DEST_CHECK_EN: ejected packets not addressed
// to (NODE_X, NODE_Y) are accepted on the link but dropped and counted in a
// saturating 8-bit misroute counter, readable (and cleared) via addr 1.
module mesh_nic
    import mesh_pkg::*;
#(
    parameter int PACKET_WIDTH = mesh_pkg::PACKET_WIDTH,
    parameter int NODE_X       = 0,
    parameter int NODE_Y       = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    mesh_nic_if.slave               bus,
    output logic                    net_so,
    input  logic                    net_ri,
    output logic [PACKET_WIDTH-1:0] net_do,
    input  logic                    net_si,
    output logic                    net_ro,
    input  logic [PACKET_WIDTH-1:0] net_di
);

    // Node coordinates are 4-bit fields in the packet; catch bad instances early.
    if (NODE_X < 0 || NODE_X > 15 || NODE_Y < 0 || NODE_Y > 15) begin : g_bad_node
        $error("mesh_nic: NODE_X/NODE_Y out of 4-bit range");
    end

    chan_state_t             out_state;
    chan_state_t             in_state;
    logic [PACKET_WIDTH-1:0] obuf_data;
    logic [PACKET_WIDTH-1:0] ibuf_data;
    logic                    obuf_full;
    logic                    ibuf_full;

    logic rd;
    logic wr;
    logic ibuf_take;
    logic link_in_fire;
    logic dest_ok;

    assign rd = bus.nic_en && !bus.nic_wr_en;
    assign wr = bus.nic_en &&  bus.nic_wr_en;

    assign obuf_full = (out_state == CHAN_FULL);
    assign ibuf_full = (in_state  == CHAN_FULL);

    // Link outputs come straight from the buffer state registers.
    assign net_so = obuf_full;
    assign net_do = obuf_full ? obuf_data : '0;
    assign net_ro = !ibuf_full;

    assign link_in_fire = net_si && net_ro;
    assign ibuf_take    = rd && (bus.addr == ADDR_IBUF);

`ifdef MESH_NIC_DEST_CHECK_EN
    logic [7:0] misroute_cnt;
    logic       misroute;

    assign dest_ok  = (net_di[DEST_X_MSB:DEST_X_LSB] == 4'(NODE_X)) &&
                      (net_di[DEST_Y_MSB:DEST_Y_LSB] == 4'(NODE_Y));
    assign misroute = link_in_fire && !dest_ok;

    // A status read returns the old count; a misroute on that same edge
    // restarts the count at 1 so it is not lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misroute_cnt <= '0;
        end else if (rd && (bus.addr == ADDR_ISTAT)) begin
            misroute_cnt <= misroute ? 8'd1 : 8'd0;
        end else if (misroute && (misroute_cnt != 8'hFF)) begin
            misroute_cnt <= misroute_cnt + 8'd1;
        end
    end
`else
    assign dest_ok = 1'b1;
`endif

    nic_chan_buf #(.W(PACKET_WIDTH)) u_obuf (
        .clk       (clk),
        .rst_n     (reset),
        .load      (wr && (bus.addr == ADDR_OBUF)),
        .load_data (bus.d_in),
        .unload    (net_ri),
        .state     (out_state),
        .data      (obuf_data)
    );

    nic_chan_buf #(.W(PACKET_WIDTH)) u_ibuf (
        .clk       (clk),
        .rst_n     (reset),
        .load      (link_in_fire && dest_ok),
        .load_data (net_di),
        .unload    (ibuf_take),
        .state     (in_state),
        .data      (ibuf_data)
    );

    // Read data register: only reads of addr 0/1/3 update it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.d_out <= '0;
        end else if (rd) begin
            case (bus.addr)
                ADDR_IBUF:  bus.d_out <= ibuf_data;
`ifdef MESH_NIC_DEST_CHECK_EN
                ADDR_ISTAT: bus.d_out <= {misroute_cnt, {(PACKET_WIDTH-9){1'b0}}, ibuf_full};
`else
                ADDR_ISTAT: bus.d_out <= {{(PACKET_WIDTH-1){1'b0}}, ibuf_full};
`endif
                ADDR_OSTAT: bus.d_out <= {{(PACKET_WIDTH-1){1'b0}}, obuf_full};
                default:    bus.d_out <= bus.d_out;
            endcase
        end
    end

endmodule

// File: tb/tb_mesh_nic.sv
module tb_mesh_nic;
    import mesh_pkg::*;

`ifdef MESH_NIC_DEST_CHECK_EN
    localparam int NX = 1;
    localparam int NY = 2;
`else
    localparam int NX = 0;
    localparam int NY = 0;
`endif
    localparam logic [3:0] NX4 = 4'(NX);
    localparam logic [3:0] NY4 = 4'(NY);
    localparam logic [63:0] NODE_FIELDS = {8'h00, NX4, NY4, 48'h0};
    localparam logic [63:0] EJ_PKT      = 64'h0000_0000_0000_00A5 | NODE_FIELDS;
    localparam logic [63:0] INJ_PKT     = 64'h0012_0000_DEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        net_so, net_ri, net_si, net_ro;
    logic [63:0] net_do, net_di;

    int total = 0;
    int bad   = 0;

    logic [63:0] out_q[$];
    logic [63:0] rd_q[$];

    mesh_nic_if #(.W(64)) bus ();

    mesh_nic #(.PACKET_WIDTH(64), .NODE_X(NX), .NODE_Y(NY)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus.slave),
        .net_so (net_so),
        .net_ri (net_ri),
        .net_do (net_do),
        .net_si (net_si),
        .net_ro (net_ro),
        .net_di (net_di)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic cpu_write(input logic [1:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        bus.nic_en = 1'b1; bus.nic_wr_en = 1'b1; bus.addr = a; bus.d_in = d;
        @(posedge clk); #1;
        bus.nic_en = 1'b0; bus.nic_wr_en = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [1:0] a, input logic [63:0] exp);
        @(posedge clk); #1;
        bus.nic_en = 1'b1; bus.nic_wr_en = 1'b0; bus.addr = a;
        rd_q.push_back(exp);
        @(posedge clk); #1;
        bus.nic_en = 1'b0;
        check(tag, bus.d_out, rd_q.pop_front());
    endtask

    task automatic eject(input logic [63:0] d);
        @(posedge clk); #1;
        net_si = 1'b1; net_di = d;
        @(posedge clk); #1;
        net_si = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // scoreboard for injected packets: a transfer happens on the next edge
    // whenever send and ready are both high at the falling edge
    always @(negedge clk) begin
        if (reset && net_so && net_ri) begin
            if (out_q.size() == 0) check("inj_unexpected", 64'd1, 64'd0);
            else                   check("inj_data", net_do, out_q.pop_front());
        end
    end

    initial begin
        logic [63:0] v;
        int budget;

        reset = 1'b0;
        net_ri = 1'b0; net_si = 1'b0; net_di = '0;
        bus.addr = '0; bus.d_in = '0; bus.nic_en = 1'b0; bus.nic_wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        check("rst_so", {63'b0, net_so}, 64'd0);
        check("rst_ro", {63'b0, net_ro}, 64'd1);
        check("rst_do", net_do, 64'd0);
        check("rst_dout", bus.d_out, 64'd0);
        cpu_read("rst_istat", ADDR_ISTAT, 64'd0);
        cpu_read("rst_ostat", ADDR_OSTAT, 64'd0);

        // injection, router ready
        net_ri = 1'b1;
        out_q.push_back(INJ_PKT);
        cpu_write(ADDR_OBUF, INJ_PKT);
        check("inj_so_high", {63'b0, net_so}, 64'd1);
        check("inj_do", net_do, INJ_PKT);
        step();
        check("inj_so_low", {63'b0, net_so}, 64'd0);
        cpu_read("inj_ostat", ADDR_OSTAT, 64'd0);

        // backpressure with an ignored second write
        net_ri = 1'b0;
        v = 64'h0123_4567_89AB_CDEF;
        out_q.push_back(v);
        cpu_write(ADDR_OBUF, v);
        for (int i = 0; i < 5; i++) begin
            check("bp_so", {63'b0, net_so}, 64'd1);
            check("bp_do", net_do, v);
            if (i == 2) cpu_write(ADDR_OBUF, 64'h1);
            else        step();
        end
        cpu_read("bp_ostat", ADDR_OSTAT, 64'd1);
        net_ri = 1'b1;
        step();
        check("bp_so_low", {63'b0, net_so}, 64'd0);
        check("bp_q_empty", 64'(out_q.size()), 64'd0);

        // ejection
        eject(EJ_PKT);
        check("ej_ro_low", {63'b0, net_ro}, 64'd0);
        cpu_read("ej_istat", ADDR_ISTAT, 64'd1);
        eject(64'h5A | NODE_FIELDS);         // ibuf full: must be ignored
        cpu_read("ej_data", ADDR_IBUF, EJ_PKT);
        check("ej_ro_back", {63'b0, net_ro}, 64'd1);
        cpu_read("ej_istat_clr", ADDR_ISTAT, 64'd0);
        cpu_read("ej_stale", ADDR_IBUF, EJ_PKT);

        // d_out holds on writes and on reads of addr 2
        cpu_write(ADDR_IBUF, 64'hFFFF_0000_FFFF_0000);
        check("dout_hold_wr", bus.d_out, EJ_PKT);
        cpu_read("dout_hold_rd2", ADDR_OBUF, EJ_PKT);

        // nic_en low: no side effects
        @(posedge clk); #1;
        bus.nic_wr_en = 1'b1; bus.addr = ADDR_OBUF; bus.d_in = 64'hBAD;
        step();
        bus.nic_wr_en = 1'b0;
        check("en_low_so", {63'b0, net_so}, 64'd0);

        // random traffic
        for (int n = 0; n < 6; n++) begin
            v = {$urandom, $urandom};
            out_q.push_back(v);
            net_ri = 1'($urandom_range(0, 1));
            cpu_write(ADDR_OBUF, v);
            budget = 0;
            while (net_so && budget < 40) begin
                net_ri = 1'($urandom_range(0, 1));
                step();
                budget++;
            end
            check("rnd_inj_done", {63'b0, net_so}, 64'd0);
            v = {8'($urandom), NX4, NY4, 16'($urandom), 32'($urandom)};
            eject(v);
            cpu_read("rnd_ej", ADDR_IBUF, v);
        end
        check("rnd_q_empty", 64'(out_q.size()), 64'd0);

        // reset in the middle of traffic
        net_ri = 1'b0;
        out_q.push_back(INJ_PKT);
        cpu_write(ADDR_OBUF, INJ_PKT);
        eject(EJ_PKT);
        cpu_read("pre_rst_data", ADDR_IBUF, EJ_PKT);
        eject(EJ_PKT);
        @(posedge clk); #3;
        reset = 1'b0;
        out_q.delete();
        #1;
        check("mid_rst_so", {63'b0, net_so}, 64'd0);
        check("mid_rst_ro", {63'b0, net_ro}, 64'd1);
        check("mid_rst_do", net_do, 64'd0);
        check("mid_rst_dout", bus.d_out, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        cpu_read("post_rst_istat", ADDR_ISTAT, 64'd0);
        cpu_read("post_rst_ostat", ADDR_OSTAT, 64'd0);
        cpu_read("post_rst_ibuf", ADDR_IBUF, 64'd0);

`ifdef MESH_NIC_DEST_CHECK_EN
        eject(64'h0030_0000_0000_1111);     // dest (3,0): misrouted
        check("dc_ro_stays", {63'b0, net_ro}, 64'd1);
        cpu_read("dc_cnt", ADDR_ISTAT, {8'd1, 56'd0});
        cpu_read("dc_cnt_clr", ADDR_ISTAT, 64'd0);
        eject(64'h0012_0000_0000_2222);     // dest (1,2): ours
        cpu_read("dc_good_stat", ADDR_ISTAT, 64'd1);
        cpu_read("dc_good_data", ADDR_IBUF, 64'h0012_0000_0000_2222);
`endif

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mesh_nic.md
Name: mesh_nic

Overview:
- Network interface controller at a router's local (PE) port. It is the endpoint of the mesh send/ready/data link protocol.
- Injects processor-written 64-bit packets into the router and ejects packets arriving from the router into a processor-readable buffer.
- Each direction has a 1-entry channel buffer with a status flag.
- One instance per router in the 4x4 mesh.

Parameters:
- PACKET_WIDTH, 64, link and packet width in bits.
- NODE_X, 0, column index of the attached router (0-3).
- NODE_Y, 0, row index of the attached router (0-3).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  2  processor register select: 0 = input buffer, 1 = input status, 2 = output buffer, 3 = output status.
- d_in  in  PACKET_WIDTH  processor write data.
- d_out  out  PACKET_WIDTH  processor read data, registered.
- nic_en  in  1  processor access enable.
- nic_wr_en  in  1  1 = write, 0 = read; qualified by nic_en.
- net_so  out  1  send to router local input.
- net_ri  in  1  router local input ready.
- net_do  out  PACKET_WIDTH  data to router local input.
- net_si  in  1  send from router local output.
- net_ro  out  1  ready to router local output.
- net_di  in  PACKET_WIDTH  data from router local output.

Behaviour:
- Packet fields: [63] vc, [55:52] dest_x, [51:48] dest_y, [47:0] payload. Other bits pass through untouched.
- Reset (reset=0, asynchronous): obuf_full=0, ibuf_full=0, net_so=0, net_ro=1, net_do=0, d_out=0, obuf/ibuf data=0.
- Output channel (processor -> router), states OUT_EMPTY and OUT_FULL:
  - OUT_EMPTY: a write to addr 2 loads obuf from d_in and moves to OUT_FULL.
  - OUT_FULL: writes to addr 2 are ignored; data is unchanged and nothing is flagged.
  - OUT_FULL: net_so=1 and net_do=obuf, driven combinationally from the state register.
  - Transfer occurs on an edge where net_so=1 and net_ri=1. It returns to OUT_EMPTY, and net_so is 0 in the next cycle.
  - Minimum latency from write to net_so high is 1 cycle. At most one packet is injected every 2 cycles.
  - A write to addr 2 on the same edge as a transfer is ignored, because the buffer is full at that edge.
- Input channel (router -> processor), states IN_EMPTY and IN_FULL:
  - net_ro = ~ibuf_full.
  - On an edge with net_si=1 and net_ro=1: ibuf <= net_di and the state moves to IN_FULL.
  - net_si while net_ro=0 is a protocol violation by the router. It is ignored.
  - A read of addr 0 (nic_en=1, nic_wr_en=0) returns ibuf on d_out on the next cycle and clears ibuf_full on that edge. net_ro rises the following cycle.
  - A read of addr 0 while IN_EMPTY returns the stale ibuf and does not change state.
  - A simultaneous read-clear and new arrival is impossible, because net_ro=0 while full.
- Status reads:
  - addr 1: d_out = {63'b0, ibuf_full}.
  - addr 3: d_out = {63'b0, obuf_full}.
  - Status reflects the value before the edge.
- d_out:
  - Updated only on a read. It holds its value otherwise.
  - Writes to addr 0, 1 or 3 and reads of addr 2 have no effect, and d_out holds.
- nic_en=0: no processor side effects; the link handshakes continue.
- Reset mid-transfer: in-flight buffer contents are discarded and net_so drops asynchronously.

Optional Feature:
- Macro: MESH_NIC_DEST_CHECK_EN.
- Defined:
  - An ejected packet whose dest_x/dest_y differ from NODE_X/NODE_Y is accepted on the link (handshake completes) but not stored.
  - An 8-bit saturating counter misroute_cnt increments for each such packet.
  - Reading addr 1 returns {misroute_cnt, 55'b0, ibuf_full}, with misroute_cnt in bits [63:56]; a read of addr 1 clears misroute_cnt.
  - misroute_cnt resets to 0.
- Undefined: all ejected packets are stored; no counter is present, and addr 1 reads as in the base behaviour.

Decomposition:
- Package mesh_pkg holds:
  - PACKET_WIDTH default.
  - Field bit positions (VC_BIT, DEST_X_MSB/LSB, DEST_Y_MSB/LSB).
  - Address constants ADDR_IBUF, ADDR_ISTAT, ADDR_OBUF, ADDR_OSTAT.
- Sub-module nic_chan_buf: a 1-entry buffer with load/unload, a full flag and a data register. It is instantiated twice, once per direction.

Test Plan:
- Reset: assert reset=0 mid-run -> net_so=0, net_ro=1, d_out=0 immediately; status reads return 0 after release.
- Injection: write addr 2 with 64'h0012_0000_DEAD_BEEF and net_ri=1 -> net_so=1 with net_do equal to that value for exactly one cycle, and obuf status reads 0 afterwards.
- Backpressure:
  - Write addr 2 while net_ri=0 for 5 cycles -> net_so stays 1 and data is stable.
  - A second write of 64'h1 in that window is ignored, and the first packet is delivered when net_ri=1.
- Ejection:
  - net_si=1 with net_di=64'h0000_0000_0000_00A5 -> net_ro=0 next cycle, addr 1 reads 1, addr 0 reads 64'hA5.
  - net_ro returns to 1 the cycle after the read.
- Full input: a second net_si while ibuf is full -> ignored; the ibuf value is unchanged.
- Dest check (MESH_NIC_DEST_CHECK_EN, NODE_X=1, NODE_Y=2):
  - Eject a packet with dest (3,0) -> not stored, and addr 1 reads bits [63:56]=8'd1.
  - Eject a packet with dest (1,2) -> stored.
